// File: rtl/frame_stack_ctrl_pkg.sv
// Purpose: shared frame constants, FSM state encoding and frame-word helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: NWORDS/FRAME_W frame geometry, ST_* state codes, frame_word() slice helper.
package frame_stack_ctrl_pkg;

  // Registers 0..14 form one saved frame; the register file uses the same sizes.
  localparam int NWORDS  = 15;
  localparam int FRAME_W = 16 * NWORDS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_RESTORE = 2'd3;

  // Word idx of a frame lives at bits [16*idx+15 : 16*idx].
  function automatic logic [15:0] frame_word(input logic [FRAME_W-1:0] frame, input int idx);
    return frame[16*idx +: 16];
  endfunction

endpackage

// File: rtl/frame_shadow_reg.sv
// Purpose: frame-wide shadow register with parallel snapshot load and per-word access.
// Latency: writes visible the cycle after load/wr_en; rd_data and frame are combinational.
// Backpressure: none; the owner decides when to load or write.
// Ports: clk/reset; load+snap (whole frame); wr_en/wr_idx/wr_data (one word);
//        rd_idx/rd_data (one word); frame (full image).
module frame_shadow_reg #(
  parameter int NWORDS = 15,
  parameter int CW     = $clog2(NWORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [16*NWORDS-1:0]  snap,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_idx,
  input  logic [15:0]           wr_data,
  input  logic [CW-1:0]         rd_idx,
  output logic [15:0]           rd_data,
  output logic [16*NWORDS-1:0]  frame
);

  logic [16*NWORDS-1:0] shadow;

  // load and wr_en are never requested together by the controller;
  // load wins if they ever coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= snap;
    end else if (wr_en) begin
      shadow[{wr_idx, 4'b0000} +: 16] <= wr_data;
    end
  end

  assign rd_data = shadow[{rd_idx, 4'b0000} +: 16];
  assign frame   = shadow;

endmodule

// File: rtl/frame_stack_ctrl.sv
// Purpose: saves the register-file frame to a memory stack on call, reloads it on return.
// Latency: call = NWORDS busy cycles, return = NWORDS+1 busy cycles, plus one per memory wait.
// Backpressure: mem_ready=0 holds address/data/strobe; busy stalls the core; requests while busy are dropped.
// Ports: clk/reset; call_req/ret_req from control; fc_snap/fc_restore/restore to the register file;
//        mem_addr/mem_wdata/mem_we/mem_re/mem_rdata/mem_ready to data memory;
//        busy/done/depth/err_overflow/err_underflow status.
module frame_stack_ctrl #(
  parameter int            NWORDS    = frame_stack_ctrl_pkg::NWORDS,
  parameter int            MAX_DEPTH = 16,
  parameter int            AW        = 16,
  parameter logic [AW-1:0] BASE_ADDR = 16'hF000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic                  ret_req,
  input  logic [16*NWORDS-1:0]  fc_snap,
  output logic [16*NWORDS-1:0]  fc_restore,
  output logic                  restore,
  output logic [AW-1:0]         mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            depth,
  output logic                  err_overflow,
  output logic                  err_underflow
);
  import frame_stack_ctrl_pkg::*;

  localparam int CW = $clog2(NWORDS);

  logic [1:0]    state;
  logic [AW-1:0] sp;
  logic [CW-1:0] cnt;
  logic [15:0]   shadow_word;
  logic          last_word;
  logic          shadow_load;
  logic          shadow_wr;
  logic          stack_full;
  logic          stack_empty;

  assign last_word   = (cnt == CW'(NWORDS - 1));
  assign stack_full  = (depth == 5'(MAX_DEPTH));
  assign stack_empty = (depth == 5'd0);

  // Snapshot only on an accepted call; the simultaneous-request error leaves the shadow alone.
  assign shadow_load = (state == ST_IDLE) && call_req && !ret_req && !stack_full;
  assign shadow_wr   = (state == ST_LOAD) && mem_ready;

  frame_shadow_reg #(
    .NWORDS (NWORDS),
    .CW     (CW)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .load    (shadow_load),
    .snap    (fc_snap),
    .wr_en   (shadow_wr),
    .wr_idx  (cnt),
    .wr_data (mem_rdata),
    .rd_idx  (cnt),
    .rd_data (shadow_word),
    .frame   (fc_restore)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      sp            <= BASE_ADDR;
      depth         <= 5'd0;
      cnt           <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (call_req && ret_req) begin
            err_overflow  <= 1'b1;
            err_underflow <= 1'b1;
          end else if (call_req) begin
            if (stack_full) begin
              err_overflow <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= ST_SAVE;
            end
          end else if (ret_req) begin
            if (stack_empty) begin
              err_underflow <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= ST_LOAD;
            end
          end
        end
        ST_SAVE: begin
          if (mem_ready) begin
            if (last_word) begin
              cnt   <= '0;
              sp    <= sp + AW'(NWORDS);
              depth <= depth + 5'd1;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (mem_ready) begin
            if (last_word) begin
              cnt   <= '0;
              state <= ST_RESTORE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_RESTORE: begin
          sp    <= sp - AW'(NWORDS);
          depth <= depth - 5'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port and pulses are decoded from state so a wait cycle holds them unchanged.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = sp;
    mem_wdata = 16'h0000;
    restore   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_SAVE: begin
        mem_we    = 1'b1;
        mem_addr  = sp + AW'(cnt);
        mem_wdata = shadow_word;
        done      = mem_ready && last_word;
      end
      ST_LOAD: begin
        mem_re   = 1'b1;
        // sp points one past the newest frame; step back to its first word.
        mem_addr = sp - AW'(NWORDS) + AW'(cnt);
      end
      ST_RESTORE: begin
        restore = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_stack_ctrl.sv
// Purpose: self-checking bench for frame_stack_ctrl against a stack-of-frames model.
// Latency: n/a.
// Backpressure: drives mem_ready as always-ready, random, or a 3-cycle stall on word 5.
module tb_frame_stack_ctrl;
  import frame_stack_ctrl_pkg::*;

  localparam int          NW   = NWORDS;
  localparam int          FW   = FRAME_W;
  localparam logic [15:0] BASE = 16'hF000;

  logic          clk = 1'b0;
  logic          reset, call_req, ret_req, mem_ready;
  logic [FW-1:0] fc_snap, fc_restore;
  logic          restore, mem_we, mem_re, busy, done, err_overflow, err_underflow;
  logic [15:0]   mem_addr, mem_wdata, mem_rdata;
  logic [4:0]    depth;

  frame_stack_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .call_req      (call_req),
    .ret_req       (ret_req),
    .fc_snap       (fc_snap),
    .fc_restore    (fc_restore),
    .restore       (restore),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .busy          (busy),
    .done          (done),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: accepts a write or completes a read when mem_ready is high.
  logic [15:0] tb_mem [0:65535];
  always @(posedge clk) if (mem_we && mem_ready) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_re ? tb_mem[mem_addr] : 16'h0000;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: saved frames, newest at the back.
  logic [FW-1:0] stk[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sp_model();
    return BASE + 16'(stk.size() * NW);
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < NW; i++) f[16*i +: 16] = 16'($urandom);
    return f;
  endfunction

  // mode 0: always ready; 1: random waits; 2: three wait cycles on word 5.
  task automatic drive_ready(input int mode, input int w, inout int stalls);
    case (mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (w == 5 && stalls < 3) begin
          mem_ready = 1'b0;
          stalls++;
        end else begin
          mem_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic run_call(input logic [FW-1:0] f, input int mode, input int exp_cyc);
    int            cyc = 0;
    int            w = 0;
    int            waits = 0;
    int            stalls = 0;
    bit            got = 1'b0;
    logic [15:0]   sp0 = sp_model();
    logic [FW-1:0] back;
    fc_snap  = f;
    call_req = 1'b1;
    tick();
    call_req = 1'b0;
    while (!got && cyc < 200) begin
      drive_ready(mode, w, stalls);
      #1;
      cyc++;
      if (w < NW) begin
        chk("save_bus", {mem_we, mem_re, restore, mem_addr, mem_wdata},
            {1'b1, 1'b0, 1'b0, sp0 + 16'(w), frame_word(f, w)});
        chk("save_done", done, mem_ready && (w == NW - 1));
      end
      if (mem_ready) begin
        if (done) got = 1'b1;
        w++;
      end else begin
        waits++;
      end
      tick();
    end
    chk("call_timeout", got, 1'b1);
    chk("call_cycles", cyc, (exp_cyc >= 0) ? exp_cyc : NW + waits);
    for (int i = 0; i < NW; i++) back[16*i +: 16] = tb_mem[sp0 + 16'(i)];
    chk("call_mem_image", back, f);
    stk.push_back(f);
    chk("call_after", {busy, mem_we, done}, 3'b000);
    chk("call_depth", depth, stk.size());
    mem_ready = 1'b0;
  endtask

  task automatic run_ret(input int mode);
    int            cyc = 0;
    int            w = 0;
    int            waits = 0;
    int            stalls = 0;
    bit            got = 1'b0;
    logic [15:0]   sp0 = sp_model();
    logic [FW-1:0] exp_f = stk[$];
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    while (!got && cyc < 200) begin
      drive_ready(mode, w, stalls);
      #1;
      cyc++;
      if (w < NW) begin
        chk("load_bus", {mem_re, mem_we, restore, done, mem_addr},
            {1'b1, 1'b0, 1'b0, 1'b0, sp0 - 16'(NW) + 16'(w)});
        if (mem_ready) w++;
        else waits++;
      end else begin
        chk("restore_cycle", {restore, done, mem_re, mem_we}, 4'b1100);
        chk("restore_image", fc_restore, exp_f);
        got = 1'b1;
      end
      tick();
    end
    chk("ret_timeout", got, 1'b1);
    chk("ret_cycles", cyc, NW + 1 + waits);
    void'(stk.pop_back());
    chk("ret_after", {busy, restore, done, mem_re}, 4'b0000);
    chk("ret_depth", depth, stk.size());
    mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] fa, fb, f1;
    logic [15:0]   sp0;
    reset     = 1'b1;
    call_req  = 1'b0;
    ret_req   = 1'b0;
    mem_ready = 1'b0;
    fc_snap   = '0;
    tick();
    tick();
    chk("rst_ctrl", {busy, done, restore, mem_we, mem_re, err_overflow, err_underflow, depth}, 12'h000);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_image", fc_restore, '0);
    reset = 1'b0;
    tick();

    // Known pattern 0x0100+i, zero-wait: 15-cycle call, then its return.
    for (int i = 0; i < NW; i++) f1[16*i +: 16] = 16'h0100 + 16'(i);
    run_call(f1, 0, 15);
    chk("mem_f000", tb_mem[16'hF000], 16'h0100);
    chk("mem_f00e", tb_mem[16'hF00E], 16'h010E);
    run_ret(0);

    // Nested frames: B lands at 0xF00F and comes back first.
    fa = rand_frame();
    fb = rand_frame();
    run_call(fa, 0, 15);
    run_call(fb, 1, -1);
    chk("mem_f00f", tb_mem[16'hF00F], frame_word(fb, 0));
    run_ret(1);
    run_ret(0);

    // Underflow at depth 0: one-cycle pulse, no strobe.
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    chk("underflow", {err_underflow, err_overflow, busy, mem_re, mem_we, depth}, {5'b10000, 5'd0});
    tick();
    chk("underflow_end", {err_underflow, err_overflow, busy}, 3'b000);

    // Simultaneous requests at depth 0.
    call_req = 1'b1;
    ret_req  = 1'b1;
    tick();
    call_req = 1'b0;
    ret_req  = 1'b0;
    chk("both_req", {err_overflow, err_underflow, busy, mem_we, mem_re, depth}, {5'b11000, 5'd0});
    tick();
    chk("both_req_end", {err_overflow, err_underflow, busy}, 3'b000);

    // Three wait states on word 5: 18-cycle call.
    run_call(rand_frame(), 2, 18);
    run_ret(1);

    // Fill to MAX_DEPTH, then a 17th call overflows.
    for (int k = 0; k < 16; k++) run_call(rand_frame(), 1, -1);
    fc_snap  = rand_frame();
    call_req = 1'b1;
    tick();
    call_req = 1'b0;
    chk("overflow", {err_overflow, err_underflow, busy, mem_we, depth}, {4'b1000, 5'd16});
    tick();
    chk("overflow_end", {err_overflow, busy, depth}, {2'b00, 5'd16});

    call_req = 1'b1;
    ret_req  = 1'b1;
    tick();
    call_req = 1'b0;
    ret_req  = 1'b0;
    chk("both_req_full", {err_overflow, err_underflow, busy, depth}, {3'b110, 5'd16});
    tick();

    for (int k = 0; k < 16; k++) run_ret(1);

    // Reset during LOAD word 7 abandons the return.
    run_call(rand_frame(), 0, 15);
    sp0     = sp_model();
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      mem_ready = 1'b1;
      #1;
      chk("abort_no_restore", restore, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("abort_addr_w7", {mem_re, mem_addr}, {1'b1, sp0 - 16'(NW) + 16'd7});
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    mem_ready = 1'b0;
    stk.delete();
    chk("abort_state", {busy, restore, done, mem_re, mem_we, depth}, 10'h000);
    chk("abort_addr", mem_addr, BASE);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_idle", {restore, busy}, 2'b00);
    end
    // Stack pointer back at base: next frame must go to 0xF000.
    run_call(rand_frame(), 1, -1);
    run_ret(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_stack_ctrl.md
Name: frame_stack_ctrl

Overview:
Sequences procedure-call context save/restore for the 64x16 register file. On a call, it snapshots the 240-bit frame (registers 0-14) and writes it word-by-word to data memory as a stack frame. On a return, it reads the frame back and pulses the register file's restore input with the rebuilt 240-bit image. It sits between the control unit, the register file fcOut/fcIn/restore pins and one data-memory port, and stalls the core via busy.

Parameters:
NWORDS, 15, registers per frame (frame width = 16*NWORDS bits)
MAX_DEPTH, 16, maximum nested frames
AW, 16, memory address width
BASE_ADDR, 16'hF000, word address of the first stack frame (stack grows upward)

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
call_req  input  1  one-cycle request to save the current frame
ret_req  input  1  one-cycle request to restore the newest frame
fc_snap  input  16*NWORDS  register file fcOut; word i at bits [16i+15:16i]
fc_restore  output  16*NWORDS  image to register file fcIn
restore  output  1  one-cycle pulse to register file restore
mem_addr  output  AW  memory word address
mem_wdata  output  16  memory write data
mem_we  output  1  write strobe, held until mem_ready
mem_re  output  1  read strobe, held until mem_ready
mem_rdata  input  16  read data, valid in the cycle mem_ready=1 with mem_re
mem_ready  input  1  memory accepts/completes the current access this cycle
busy  output  1  high whenever state != IDLE; core must stall
done  output  1  one-cycle pulse at completion of a call or return
depth  output  5  current number of saved frames (0..MAX_DEPTH)
err_overflow  output  1  one-cycle pulse: call rejected, stack full
err_underflow  output  1  one-cycle pulse: return rejected, stack empty

Behaviour:
- Reset values: state IDLE, sp=BASE_ADDR, depth=0, shadow=0, word counter=0. All outputs 0, except fc_restore=0 and mem_addr=BASE_ADDR.
- States: IDLE, SAVE, LOAD, RESTORE.
- IDLE, call_req only:
  - depth==MAX_DEPTH: pulse err_overflow next cycle and stay IDLE.
  - Otherwise latch fc_snap into the shadow register, cnt=0, go to SAVE.
- IDLE, ret_req only:
  - depth==0: pulse err_underflow and stay IDLE.
  - Otherwise cnt=0, go to LOAD.
- IDLE, call_req and ret_req together: treated as an error. Pulse both err_overflow and err_underflow, no state change.
- SAVE: mem_we=1, mem_addr=sp+cnt, mem_wdata=shadow word cnt.
  - On mem_ready, cnt++.
  - On mem_ready with cnt==NWORDS-1: sp+=NWORDS, depth++, done pulse, go to IDLE.
- LOAD: mem_re=1, mem_addr=sp-NWORDS+cnt.
  - On mem_ready, write mem_rdata into shadow word cnt and increment cnt.
  - On mem_ready with cnt==NWORDS-1: go to RESTORE.
- RESTORE (exactly 1 cycle): restore=1, fc_restore=shadow, sp-=NWORDS, depth--, done pulse, go to IDLE.
- fc_restore holds the shadow value at all times; only meaningful while restore=1.
- Requests arriving while busy are ignored and not queued. The core is stalled, so none are expected.
- mem_we and mem_re are never high together. Both are 0 in IDLE and RESTORE.
- Latency with zero-wait memory (mem_ready tied 1):
  - Call: NWORDS cycles busy, done on the last SAVE cycle.
  - Return: NWORDS+1 cycles busy, restore and done coincide.
- Each wait state (mem_ready=0) adds one cycle and holds addr/data/strobe stable.
- Address arithmetic is modulo 2^AW. Integrators ensure BASE_ADDR+MAX_DEPTH*NWORDS <= 2^AW.
- Reset mid-operation aborts immediately to reset values. Partial memory writes are abandoned and restore is not pulsed.

Decomposition:
- Shared package holds: the state encoding (IDLE/SAVE/LOAD/RESTORE), the NWORDS=15 frame-size constant, and the frame-word bit-slice helper (word i = bits [16i+15:16i]). The register file uses the same constants.
- One natural sub-module: frame_shadow_reg. It is the 240-bit shadow with parallel load from fc_snap, indexed 16-bit word write, and indexed word read mux.

Test Plan:
- Reset, then call with fc_snap word i = 16'h0100+i, mem_ready=1 -> writes 0x0100..0x010E to 0xF000..0xF00E over 15 cycles; done on cycle 15; depth=1; busy low after.
- Following ret_req, memory returning the stored values -> reads 0xF000..0xF00E; restore pulses once with fc_restore equal to the original snapshot; depth=0.
- Two nested calls (snapshots A, then B) followed by two returns -> frame B at 0xF00F..0xF01D restored first, then A; final sp=0xF000.
- ret_req at depth 0 -> err_underflow for 1 cycle, no memory strobe. 16 calls followed by a 17th -> err_overflow, depth stays 16.
- mem_ready low for 3 cycles on SAVE word 5 -> mem_addr=0xF005 and mem_wdata held stable; call completes in 18 cycles.
- Simultaneous call_req+ret_req in IDLE -> both error pulses, no state change. reset asserted during LOAD word 7 -> IDLE, depth=0, sp=0xF000, no restore pulse.
